// File: rtl/cpu_step_sequencer.sv
// Multi-cycle IF/DE/MEM/WB step sequencer for the RV32I core with handshake memories,
// debug halt and bus/PC traps. Optional counters: define CPU_STEP_PERF_COUNTER_EN.
module cpu_step_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instruction,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] exec_pc_next,
  input  logic              exec_need_write_rd,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   load_data,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_write_enable,
  output logic              rd_write_enable,
  input  logic              halt_req,
  output logic              halted,
  output logic              bus_error,
`ifdef CPU_STEP_PERF_COUNTER_EN
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count,
`endif
  output logic [2:0]        state_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_DE   = 3'd1,
    ST_MEM  = 3'd2,
    ST_WB   = 3'd3,
    ST_HALT = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   load_data_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              bus_error_q;
  logic              pc_aligned;
  logic              wait_expired;

  assign pc_aligned   = (exec_pc_next[1:0] == 2'b00);
  assign wait_expired = (wait_q == WAIT_LAST);
  assign wait_d       = wait_q + WAIT_W'(1);

  // Every transition below clears the wait counter so each state starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IF;
      pc_q        <= RESET_PC;
      instr_q     <= XLEN'(32'h0000_0013);
      load_data_q <= '0;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IF: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= ST_DE;
            wait_q  <= '0;
          end else if (wait_expired) begin
            bus_error_q <= 1'b1;
            state_q     <= ST_ERR;
            wait_q      <= '0;
          end else begin
            wait_q <= wait_d;
          end
        end
        ST_DE: begin
          state_q <= (is_load || is_store) ? ST_MEM : ST_WB;
          wait_q  <= '0;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            // load+store together behaves as a store, so load_data is left alone
            if (is_load && !is_store) begin
              load_data_q <= dmem_rdata;
            end
            state_q <= ST_WB;
            wait_q  <= '0;
          end else if (wait_expired) begin
            bus_error_q <= 1'b1;
            state_q     <= ST_ERR;
            wait_q      <= '0;
          end else begin
            wait_q <= wait_d;
          end
        end
        ST_WB: begin
          wait_q <= '0;
          if (!pc_aligned) begin
            bus_error_q <= 1'b1;
            state_q     <= ST_ERR;
          end else begin
            pc_q    <= exec_pc_next;
            state_q <= halt_req ? ST_HALT : ST_IF;
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            state_q <= ST_IF;
            wait_q  <= '0;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          bus_error_q <= 1'b1;
          state_q     <= ST_ERR;
          wait_q      <= '0;
        end
      endcase
    end
  end

`ifdef CPU_STEP_PERF_COUNTER_EN
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] retire_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q  <= '0;
      retire_count_q <= '0;
    end else begin
      if (state_q != ST_HALT && state_q != ST_ERR) begin
        cycle_count_q <= cycle_count_q + CNT_W'(1);
      end
      if (state_q == ST_WB && pc_aligned) begin
        retire_count_q <= retire_count_q + CNT_W'(1);
      end
    end
  end

  assign cycle_count  = cycle_count_q;
  assign retire_count = retire_count_q;
`endif

  // Strobes are gated by rst_n so nothing is requested while reset is held.
  assign imem_req        = rst_n && (state_q == ST_IF);
  assign imem_addr       = pc_q;
  assign dmem_req        = rst_n && (state_q == ST_MEM);
  assign dmem_we         = dmem_req && is_store;
  assign pc_write_enable = rst_n && (state_q == ST_WB) && pc_aligned;
  assign rd_write_enable = rst_n && (state_q == ST_WB) && exec_need_write_rd;
  assign halted          = (state_q == ST_HALT);
  assign instruction     = instr_q;
  assign load_data       = load_data_q;
  assign pc              = pc_q;
  assign bus_error       = bus_error_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Self-checking bench for cpu_step_sequencer: table vectors, randomized instruction
// stream against a per-instruction reference model, and hand-written trap/reset cases.
module tb_cpu_step_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] exec_pc_next = '0;
  logic        exec_need_write_rd = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] load_data;
  logic [31:0] pc;
  logic        pc_write_enable;
  logic        rd_write_enable;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        bus_error;
  logic [2:0]  state_o;
`ifdef CPU_STEP_PERF_COUNTER_EN
  logic [63:0] cycle_count;
  logic [63:0] retire_count;
`endif

  cpu_step_sequencer #(
    .XLEN(32), .ADDR_W(32), .RESET_PC(RPC), .MEM_TIMEOUT(TO), .CNT_W(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction(instruction),
    .is_load(is_load), .is_store(is_store),
    .exec_pc_next(exec_pc_next), .exec_need_write_rd(exec_need_write_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .load_data(load_data),
    .pc(pc), .pc_write_enable(pc_write_enable), .rd_write_enable(rd_write_enable),
    .halt_req(halt_req), .halted(halted), .bus_error(bus_error),
`ifdef CPU_STEP_PERF_COUNTER_EN
    .cycle_count(cycle_count), .retire_count(retire_count),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wi;
    int          wd;
    bit          ld;
    bit          st;
    logic [31:0] insn;
    logic [31:0] rdata;
    logic [31:0] next;
    bit          need;
    bit          halt;
    logic [31:0] exp_pc;
    logic [31:0] exp_ld;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  // Architectural reference state, advanced once per completed instruction.
  logic [31:0] m_pc;
  logic [31:0] m_insn;
  logic [31:0] m_ld;
  int unsigned m_retire;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input logic [2:0] st);
    chk("state_o", 64'(state_o), 64'(st));
    chk("imem_req", 64'(imem_req), 64'(st == 3'd0));
    chk("dmem_req", 64'(dmem_req), 64'(st == 3'd2));
    chk("dmem_we", 64'(dmem_we), 64'(st == 3'd2 && is_store));
    chk("pc_write_enable", 64'(pc_write_enable), 64'(st == 3'd3 && exec_pc_next[1:0] == 2'b00));
    chk("rd_write_enable", 64'(rd_write_enable), 64'(st == 3'd3 && exec_need_write_rd));
    chk("halted", 64'(halted), 64'(st == 3'd4));
    chk("pc", 64'(pc), 64'(m_pc));
    chk("imem_addr", 64'(imem_addr), 64'(m_pc));
  endtask

  // Called at posedge+1; leaves the DUT out of reset at posedge+1 ready to fetch.
  task automatic do_reset();
    rst_n = 1'b0;
    exec_need_write_rd = 1'b1;
    exec_pc_next = 32'h0000_0040;
    #1;
    chk("rst state_o", 64'(state_o), 64'd0);
    chk("rst imem_req", 64'(imem_req), 64'd0);
    chk("rst dmem_req", 64'(dmem_req), 64'd0);
    chk("rst pc_we", 64'(pc_write_enable), 64'd0);
    chk("rst rd_we", 64'(rd_write_enable), 64'd0);
    chk("rst pc", 64'(pc), 64'(RPC));
    chk("rst instruction", 64'(instruction), 64'h13);
    chk("rst load_data", 64'(load_data), 64'd0);
    chk("rst bus_error", 64'(bus_error), 64'd0);
`ifdef CPU_STEP_PERF_COUNTER_EN
    chk("rst cycle_count", cycle_count, 64'd0);
    chk("rst retire_count", retire_count, 64'd0);
`endif
    m_pc = RPC;
    m_insn = 32'h13;
    m_ld = '0;
    m_retire = 0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    halt_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One full instruction: expected state per cycle is IF x(wi+1), DE, [MEM x(wd+1)], WB.
  task automatic run_instr(input vec_t v);
    logic [2:0] seq[$];
    bit mem;
    bit trap;
    int didx;
    logic [63:0] cyc0;
    mem  = v.ld || v.st;
    trap = (v.next[1:0] != 2'b00);
    didx = v.wi + 2 + v.wd;
    for (int i = 0; i <= v.wi; i++) seq.push_back(3'd0);
    seq.push_back(3'd1);
    if (mem) for (int j = 0; j <= v.wd; j++) seq.push_back(3'd2);
    seq.push_back(3'd3);

    is_load = v.ld;
    is_store = v.st;
    exec_pc_next = v.next;
    exec_need_write_rd = v.need;
    halt_req = v.halt;
    imem_rdata = v.insn;
    dmem_rdata = v.rdata;
    for (int k = 0; k < seq.size(); k++) begin
      imem_ready = (k == v.wi);
      dmem_ready = mem && (k == didx);
      #1;
      chk_cycle(seq[k]);
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    if (!trap) begin
      m_pc = v.next;
      m_retire++;
    end
    m_insn = v.insn;
    if (v.ld && !v.st) m_ld = v.rdata;

    chk("instruction", 64'(instruction), 64'(m_insn));
    chk("load_data", 64'(load_data), 64'(m_ld));
    chk("bus_error", 64'(bus_error), 64'(trap));
`ifdef CPU_STEP_PERF_COUNTER_EN
    chk("retire_count", retire_count, 64'(m_retire));
`endif
    $display("instr insn=%h ld=%0b st=%0b wi=%0d wd=%0d next=%h cycles=%0d halt=%0b",
             v.insn, v.ld, v.st, v.wi, v.wd, v.next, seq.size(), v.halt);

    if (!trap && v.halt) begin
`ifdef CPU_STEP_PERF_COUNTER_EN
      cyc0 = cycle_count;
`else
      cyc0 = '0;
`endif
      for (int h = 0; h < 2; h++) begin
        imem_ready = 1'b1;
        #1;
        chk_cycle(3'd4);
        @(posedge clk);
        #1;
      end
      imem_ready = 1'b0;
      halt_req = 1'b0;
      #1;
      chk_cycle(3'd4);
`ifdef CPU_STEP_PERF_COUNTER_EN
      chk("cycle_count frozen", cycle_count, cyc0);
`endif
      @(posedge clk);
      #1;
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    // table: first entry is the reset-then-addi case, then load/store/boundary/wrap cases
    tbl[0] = '{0, 0, 1'b0, 1'b0, 32'h0050_0093, 32'h0,         32'h0000_0104, 1'b1, 1'b0, 32'h0000_0104, 32'h0};
    tbl[1] = '{0, 2, 1'b1, 1'b0, 32'h0000_2083, 32'hDEAD_BEEF, 32'h0000_0108, 1'b1, 1'b0, 32'h0000_0108, 32'hDEAD_BEEF};
    tbl[2] = '{1, 0, 1'b0, 1'b1, 32'h0010_2023, 32'h1111_1111, 32'h0000_010C, 1'b0, 1'b0, 32'h0000_010C, 32'hDEAD_BEEF};
    tbl[3] = '{3, 0, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF};
    tbl[4] = '{0, 3, 1'b1, 1'b1, 32'h0010_2023, 32'h2222_2222, 32'h0000_0204, 1'b0, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF};
    tbl[5] = '{2, 1, 1'b1, 1'b0, 32'h0000_2103, 32'h3333_3333, 32'h0000_0208, 1'b1, 1'b0, 32'h0000_0208, 32'h3333_3333};
    tbl[6] = '{0, 0, 1'b0, 1'b0, 32'h0040_006F, 32'h0,         32'h0000_020C, 1'b0, 1'b1, 32'h0000_020C, 32'h3333_3333};
    tbl[7] = '{0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h3333_3333};
    tbl[8] = '{1, 0, 1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h3333_3333};
    tbl[9] = '{0, 0, 1'b1, 1'b0, 32'h0000_2183, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, 32'h0};

    @(posedge clk);
    #1;
    do_reset();

    for (int t = 0; t < 10; t++) begin
      run_instr(tbl[t]);
      chk("tbl pc", 64'(pc), 64'(tbl[t].exp_pc));
      chk("tbl load_data", 64'(load_data), 64'(tbl[t].exp_ld));
    end

    // randomized instruction stream
    for (int r = 0; r < 40; r++) begin
      rv.wi    = int'($urandom_range(0, TO - 1));
      rv.wd    = int'($urandom_range(0, TO - 1));
      rv.ld    = 1'($urandom_range(0, 1));
      rv.st    = 1'($urandom_range(0, 1));
      rv.insn  = $urandom;
      rv.rdata = $urandom;
      rv.next  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      rv.need  = 1'($urandom_range(0, 1));
      rv.halt  = ($urandom_range(0, 7) == 0);
      rv.exp_pc = '0;
      rv.exp_ld = '0;
      run_instr(rv);
    end

    // misaligned next PC traps in WB: rd commit allowed, pc held, ERR is terminal
    rv = '{0, 0, 1'b0, 1'b0, 32'h0020_0067, 32'h0, 32'h0000_0102, 1'b1, 1'b0, 32'h0, 32'h0};
    run_instr(rv);
    for (int e = 0; e < 3; e++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #1;
      chk_cycle(3'd5);
      chk("err bus_error", 64'(bus_error), 64'd1);
      @(posedge clk);
      #1;
    end
    do_reset();

    // imem never ready: ERR after TO fetch cycles, pc untouched
    is_load = 1'b0;
    is_store = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      chk_cycle(3'd0);
      @(posedge clk);
      #1;
    end
    for (int e = 0; e < 3; e++) begin
      #1;
      chk_cycle(3'd5);
      chk("imem timeout bus_error", 64'(bus_error), 64'd1);
      @(posedge clk);
      #1;
    end
    do_reset();

    // dmem never ready on a load: IF, DE, MEM x TO, then ERR with load_data unchanged
    is_load = 1'b1;
    is_store = 1'b0;
    exec_pc_next = 32'h0000_0104;
    dmem_rdata = 32'hAAAA_5555;
    imem_rdata = 32'h0000_2083;
    for (int k = 0; k < TO + 3; k++) begin
      imem_ready = (k == 0);
      #1;
      chk_cycle((k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k < TO + 2) ? 3'd2 : 3'd5);
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    chk("dmem timeout bus_error", 64'(bus_error), 64'd1);
    chk("dmem timeout load_data", 64'(load_data), 64'd0);
    $display("instr dmem timeout -> ERR");
    do_reset();

    // reset asserted while a load is in MEM: immediate abort, no strobes, pc back to reset
    rv = '{0, 0, 1'b1, 1'b0, 32'h0000_2083, 32'h5A5A_0001, 32'h0000_0300, 1'b1, 1'b0, 32'h0, 32'h0};
    run_instr(rv);
    is_load = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk_cycle(3'd0);
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    #1;
    chk_cycle(3'd1);
    @(posedge clk);
    #1;
    #1;
    chk_cycle(3'd2);
    rst_n = 1'b0;
    #1;
    chk("abort dmem_req", 64'(dmem_req), 64'd0);
    chk("abort pc_we", 64'(pc_write_enable), 64'd0);
    chk("abort rd_we", 64'(rd_write_enable), 64'd0);
    chk("abort state_o", 64'(state_o), 64'd0);
    chk("abort pc", 64'(pc), 64'(RPC));
    chk("abort load_data", 64'(load_data), 64'd0);
    $display("instr reset abort in MEM");
    @(posedge clk);
    #1;
    do_reset();
    rv = '{0, 0, 1'b0, 1'b0, 32'h0050_0093, 32'h0, 32'h0000_0104, 1'b1, 1'b0, 32'h0, 32'h0};
    run_instr(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
